// File: rtl/register_scoreboard_pkg.sv
// Scoreboard types shared with the ID-stage controller.
// The controller decodes register_invalid using reg_state_e.
package simple_pkg;

    typedef enum logic [2:0] {
        RS_READY     = 3'd0,
        RS_STALL     = 3'd1,
        RS_FWD_EXMEM = 3'd2,
        RS_FWD_MEMWB = 3'd3
    } reg_state_e;

    typedef struct packed {
        logic       vld;
        logic [2:0] adr;
        logic       ld;
    } sb_slot_t;

endpackage

// File: rtl/register_scoreboard_if.sv
// Scoreboard bundle between the pipeline controller and the scoreboard.
// The controller side is master; the scoreboard side is slave.
interface register_scoreboard_if #(
    parameter int NREG  = 8,
    parameter int CNT_W = 16
) ();
    logic                      regwrite_cur;
    logic [2:0]                regwrite_adr_id;
    logic                      from_main_mem;
    logic                      en_idex;
    logic                      flush_idex;
    logic                      en_exmem;
    logic                      flush_exmem;
    logic                      en_memwb;
    logic                      flush_memwb;
    logic                      hazard_stall;
    logic [NREG-1:0][2:0]      register_invalid;
    logic                      pipe_busy;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output regwrite_cur, regwrite_adr_id, from_main_mem,
        output en_idex, flush_idex, en_exmem, flush_exmem,
        output en_memwb, flush_memwb, hazard_stall,
        input  register_invalid, pipe_busy, stall_cnt
    );

    modport slave (
        input  regwrite_cur, regwrite_adr_id, from_main_mem,
        input  en_idex, flush_idex, en_exmem, flush_exmem,
        input  en_memwb, flush_memwb, hazard_stall,
        output register_invalid, pipe_busy, stall_cnt
    );
endinterface

// File: rtl/register_scoreboard_sb_slot_reg.sv
// One pipeline slot of the scoreboard.
// Flush clears the slot even when the enable is high.
import simple_pkg::*;

module sb_slot_reg (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  logic     flush,
    input  sb_slot_t d,
    output sb_slot_t q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (flush)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/register_scoreboard.sv
// Tracks pending register writes in EX/MEM/WB and emits per-register
// stall/forward codes for ID, plus a saturating hazard-stall counter.
import simple_pkg::*;

module register_scoreboard #(
    parameter int NREG  = 8,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    register_scoreboard_if.slave sb
);
    sb_slot_t ex_d;
    sb_slot_t ex_q;
    sb_slot_t mem_q;
    sb_slot_t wb_q;
    logic [CNT_W-1:0] cnt_q;
    logic unused_wb;

    assign ex_d.vld = sb.regwrite_cur;
    assign ex_d.adr = sb.regwrite_adr_id;
    assign ex_d.ld  = sb.from_main_mem & sb.regwrite_cur;

    sb_slot_reg u_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sb.en_idex),
        .flush (sb.flush_idex),
        .d     (ex_d),
        .q     (ex_q)
    );

    sb_slot_reg u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sb.en_exmem),
        .flush (sb.flush_exmem),
        .d     (ex_q),
        .q     (mem_q)
    );

    sb_slot_reg u_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sb.en_memwb),
        .flush (sb.flush_memwb),
        .d     (mem_q),
        .q     (wb_q)
    );

    // WB is covered by regfile write-through, so it never sets a code.
    for (genvar r = 0; r < NREG; r++) begin : g_code
        localparam logic [2:0] RA = 3'(r);
        logic ex_hit;
        logic mem_hit;
        assign ex_hit  = ex_q.vld && (ex_q.adr == RA);
        assign mem_hit = mem_q.vld && (mem_q.adr == RA);
        assign sb.register_invalid[r] =
            ex_hit  ? (ex_q.ld ? RS_STALL : RS_FWD_EXMEM) :
            mem_hit ? RS_FWD_MEMWB : RS_READY;
    end

    assign sb.pipe_busy = ex_q.vld | mem_q.vld | wb_q.vld;
    assign unused_wb    = ^{wb_q.adr, wb_q.ld};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (sb.hazard_stall && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign sb.stall_cnt = cnt_q;
endmodule

// File: tb/tb_register_scoreboard.sv
// Directed test of the register scoreboard: codes, flush/hold paths,
// counter saturation and asynchronous reset.
import simple_pkg::*;

module tb_register_scoreboard;
    localparam int NREG  = 8;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    register_scoreboard_if #(.NREG(NREG), .CNT_W(CNT_W)) sb ();

    register_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        sb.regwrite_cur    = 1'b0;
        sb.regwrite_adr_id = 3'd0;
        sb.from_main_mem   = 1'b0;
        sb.en_idex         = 1'b1;
        sb.flush_idex      = 1'b0;
        sb.en_exmem        = 1'b1;
        sb.flush_exmem     = 1'b0;
        sb.en_memwb        = 1'b1;
        sb.flush_memwb     = 1'b0;
        sb.hazard_stall    = 1'b0;
    endtask

    task automatic issue(input logic [2:0] adr, input logic ld);
        sb.regwrite_cur    = 1'b1;
        sb.regwrite_adr_id = adr;
        sb.from_main_mem   = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #3;
        n_total++;
        if (sb.register_invalid !== '0)
            $display("FAIL reset_codes got=%h want=0", sb.register_invalid);
        else n_pass++;
        n_total++;
        if (sb.pipe_busy !== 1'b0)
            $display("FAIL reset_busy got=%b want=0", sb.pipe_busy);
        else n_pass++;
        n_total++;
        if (sb.stall_cnt !== '0)
            $display("FAIL reset_cnt got=%0d want=0", sb.stall_cnt);
        else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        issue(3'd2, 1'b0);
        step();
        idle();
        n_total++;
        if (sb.register_invalid[2] !== 3'd2 || sb.register_invalid[3] !== 3'd0)
            $display("FAIL alu_p1 got=%h want r2=2 r3=0", sb.register_invalid);
        else n_pass++;
        step();
        n_total++;
        if (sb.register_invalid[2] !== 3'd3)
            $display("FAIL alu_p2 got=%0d want=3", sb.register_invalid[2]);
        else n_pass++;
        step();
        n_total++;
        if (sb.register_invalid[2] !== 3'd0 || sb.pipe_busy !== 1'b1)
            $display("FAIL alu_p3 got=%0d busy=%b want=0 busy=1",
                     sb.register_invalid[2], sb.pipe_busy);
        else n_pass++;
        step();
        n_total++;
        if (sb.pipe_busy !== 1'b0)
            $display("FAIL alu_p4_busy got=%b want=0", sb.pipe_busy);
        else n_pass++;
    endtask

    task automatic test_load_stall();
        issue(3'd5, 1'b1);
        step();
        idle();
        n_total++;
        if (sb.register_invalid[5] !== 3'd1)
            $display("FAIL ld_p1 got=%0d want=1", sb.register_invalid[5]);
        else n_pass++;
        sb.en_idex    = 1'b0;
        sb.flush_idex = 1'b1;
        step();
        idle();
        n_total++;
        if (sb.register_invalid[5] !== 3'd3)
            $display("FAIL ld_p2 got=%0d want=3", sb.register_invalid[5]);
        else n_pass++;
        step();
        n_total++;
        if (sb.register_invalid[5] !== 3'd0)
            $display("FAIL ld_p3 got=%0d want=0", sb.register_invalid[5]);
        else n_pass++;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        issue(3'd1, 1'b0);
        step();
        issue(3'd1, 1'b0);
        step();
        idle();
        n_total++;
        if (sb.register_invalid[1] !== 3'd2)
            $display("FAIL b2b_p1 got=%0d want=2", sb.register_invalid[1]);
        else n_pass++;
        step();
        n_total++;
        if (sb.register_invalid[1] !== 3'd3)
            $display("FAIL b2b_p2 got=%0d want=3", sb.register_invalid[1]);
        else n_pass++;
        step();
        n_total++;
        if (sb.register_invalid[1] !== 3'd0)
            $display("FAIL b2b_p3 got=%0d want=0", sb.register_invalid[1]);
        else n_pass++;
        step();
    endtask

    task automatic test_jump_flush();
        issue(3'd3, 1'b0);
        step();
        issue(3'd4, 1'b0);
        step();
        idle();
        n_total++;
        if (sb.register_invalid[3] !== 3'd3 || sb.register_invalid[4] !== 3'd2)
            $display("FAIL flush_pre got=%h want r3=3 r4=2", sb.register_invalid);
        else n_pass++;
        sb.flush_idex  = 1'b1;
        sb.flush_exmem = 1'b1;
        sb.flush_memwb = 1'b1;
        step();
        idle();
        n_total++;
        if (sb.register_invalid !== '0 || sb.pipe_busy !== 1'b0)
            $display("FAIL flush_all got=%h busy=%b want=0 busy=0",
                     sb.register_invalid, sb.pipe_busy);
        else n_pass++;
    endtask

    task automatic test_hold();
        issue(3'd6, 1'b0);
        step();
        idle();
        sb.en_idex  = 1'b0;
        sb.en_exmem = 1'b0;
        sb.en_memwb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (sb.register_invalid[6] !== 3'd2)
                $display("FAIL hold_c%0d got=%0d want=2", i, sb.register_invalid[6]);
            else n_pass++;
            step();
        end
        idle();
        n_total++;
        if (sb.register_invalid[6] !== 3'd2)
            $display("FAIL hold_end got=%0d want=2", sb.register_invalid[6]);
        else n_pass++;
        step();
        n_total++;
        if (sb.register_invalid[6] !== 3'd3)
            $display("FAIL hold_rel1 got=%0d want=3", sb.register_invalid[6]);
        else n_pass++;
        step();
        n_total++;
        if (sb.register_invalid[6] !== 3'd0)
            $display("FAIL hold_rel2 got=%0d want=0", sb.register_invalid[6]);
        else n_pass++;
        step();
    endtask

    task automatic test_counter_and_reset();
        sb.hazard_stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_total++;
        if (sb.stall_cnt !== 16'd3)
            $display("FAIL cnt_3 got=%0d want=3", sb.stall_cnt);
        else n_pass++;
        for (int i = 0; i < (1 << CNT_W); i++) step();
        n_total++;
        if (sb.stall_cnt !== 16'hFFFF)
            $display("FAIL cnt_sat got=%h want=ffff", sb.stall_cnt);
        else n_pass++;
        step();
        n_total++;
        if (sb.stall_cnt !== 16'hFFFF)
            $display("FAIL cnt_hold got=%h want=ffff", sb.stall_cnt);
        else n_pass++;
        sb.hazard_stall = 1'b0;
        issue(3'd7, 1'b1);
        step();
        idle();
        n_total++;
        if (sb.register_invalid[7] !== 3'd1 || sb.pipe_busy !== 1'b1)
            $display("FAIL pre_rst got=%0d busy=%b want=1 busy=1",
                     sb.register_invalid[7], sb.pipe_busy);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (sb.register_invalid !== '0 || sb.pipe_busy !== 1'b0)
            $display("FAIL async_rst_codes got=%h busy=%b want=0 busy=0",
                     sb.register_invalid, sb.pipe_busy);
        else n_pass++;
        n_total++;
        if (sb.stall_cnt !== '0)
            $display("FAIL async_rst_cnt got=%h want=0", sb.stall_cnt);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        test_reset();
        test_alu();
        test_load_stall();
        test_back_to_back();
        test_jump_flush();
        test_hold();
        test_counter_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
